swap_seq_ctrl: RTL
==================

# swap_seq_ctrl

Sequencing controller for the two-register exchange datapath. It accepts an operand pair plus a swap count over a valid/ready handshake. It then performs exactly that many same-edge exchanges of the A and B registers, one per clock, and presents the final pair on a valid/ready output port. It sits between an upstream command source and the downstream consumer of the swapped pair, and owns all sequencing of the exchange.

## Interface
Parameters:
- WIDTH, 8, data width of each operand register
- CNT_W, 4, width of the swap-count field; maximum count 2**CNT_W-1

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream job offer
- in_ready  output  1  controller can accept a job
- a_i  input  WIDTH  operand A of offered job
- b_i  input  WIDTH  operand B of offered job
- swaps_i  input  CNT_W  number of exchanges to perform
- out_valid  output  1  final pair available
- out_ready  input  1  downstream accepts final pair
- a_o  output  WIDTH  current A register
- b_o  output  WIDTH  current B register
- busy  output  1  state is not IDLE
- jobs_o  output  16  count of completed jobs, wraps 0xFFFF->0x0000

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n). Assertion immediately forces all outputs to their reset values.
- Reset values: state IDLE, A=0, B=0, cnt=0, jobs_o=0, out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, RUN, DONE. Outputs derive only from state: in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state!=IDLE). They are never combinational on in_valid or out_ready.
- IDLE: on an edge with in_valid&&in_ready, capture A<=a_i, B<=b_i and cnt<=swaps_i.
  - If swaps_i==0, go to DONE.
  - Otherwise, go to RUN.
- RUN: every edge performs a true exchange, A<=B and B<=A, both from pre-edge values, and cnt<=cnt-1.
  - When pre-edge cnt==1, the edge performs the last swap and goes to DONE.
  - in_valid is ignored; in_ready=0.
- DONE: A and B hold. On an edge with out_ready=1, go to IDLE and increment jobs_o (mod 2**16).
- a_o/b_o always show the live registers, including intermediate values during RUN. They hold their last values in IDLE after completion.
- Result rule: even N gives a_o=a_i and b_o=b_i. Odd N gives a_o=b_i and b_o=a_i.
- cnt never underflows: the decrement occurs only in RUN with cnt>=1.
- Reset mid-RUN or mid-DONE: the job is discarded, no out_valid pulse is produced and jobs_o clears.

## Timing
- Acceptance edge E0. Exactly N RUN edges follow, so out_valid is high in the cycle after edge E0+N.
- For N=0, out_valid is high in the cycle directly after E0.
- DONE persists until out_ready is sampled high. Backpressure has unbounded hold with stable a_o/b_o.
- Hand-off edge ED: out_valid drops and in_ready rises in the following cycle.
- A new job cannot be accepted on ED itself, so job-to-job spacing is N+2 cycles minimum.
- in_valid/a_i/b_i/swaps_i are sampled only on the acceptance edge. Changes at other times have no effect.
- jobs_o updates on ED and is visible in the following cycle.

## Test plan
- Reset: hold rst_n=0 mid-cycle -> immediately a_o=b_o=0, jobs_o=0, out_valid=0, in_ready=1, busy=0. Release rst_n -> remains IDLE.
- Odd count: a_i=0xA5, b_i=0x3C, swaps_i=3, out_ready=1 -> a_o toggles 0x3C,0xA5,0x3C over 3 cycles. out_valid is high 3 edges after acceptance with a_o=0x3C, b_o=0xA5. jobs_o=1.
- Even and zero count:
  - swaps_i=4 -> final a_o=0xA5, b_o=0x3C.
  - swaps_i=0 -> out_valid is high the cycle after acceptance with the pair unchanged.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, a_o/b_o stable, in_ready=0. Raise out_ready -> one hand-off, jobs_o increments once.
  - Drive in_valid=1 during RUN -> no capture.
- Max count and wrap:
  - swaps_i=15 -> 15 RUN cycles, final pair swapped.
  - Preload 65535 completions -> next completion gives jobs_o=0.
- Reset mid-RUN: assert rst_n=0 at cycle 2 of a swaps_i=10 job -> A=B=0 immediately, no out_valid. A next job after release completes normally.

Source files
------------

// File: rtl/swap_seq_ctrl.sv
// Sequencing controller for the two-register exchange datapath: accepts an
// operand pair and a swap count, exchanges A/B once per clock, then hands off.
module swap_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CNT_W-1:0] swaps_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             busy,
  output logic [15:0]      jobs_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      jobs_reg, jobs_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      jobs_reg  <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cnt_reg   <= cnt_next;
      jobs_reg  <= jobs_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cnt_next   = cnt_reg;
    jobs_next  = jobs_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a_i;
          b_next     = b_i;
          cnt_next   = swaps_i;
          state_next = (swaps_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Both sides read pre-edge values, so this is a true exchange.
        a_next = b_reg;
        b_next = a_reg;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          jobs_next  = jobs_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags depend on state alone, never on in_valid/out_ready.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign a_o       = a_reg;
  assign b_o       = b_reg;
  assign jobs_o    = jobs_reg;

endmodule
